// File: rtl/iobus_dma.sv
// Word-copy DMA initiator for the OTTER IOBUS: reads LEN words from a source
// address and writes each to a destination address, sharing the bus via REQ/GNT.
module iobus_dma #(
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [31:0]      SRC_ADDR,
  input  logic [31:0]      DST_ADDR,
  input  logic [LEN_W-1:0] LEN,
  input  logic             SRC_INC,
  input  logic             DST_INC,
  output logic             BUSY,
  output logic             DONE,
  output logic             BUS_REQ,
  input  logic             BUS_GNT,
  output logic [31:0]      IOBUS_ADDR,
  output logic [31:0]      IOBUS_OUT,
  output logic             IOBUS_WR,
  input  logic [31:0]      IOBUS_IN,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      data_reg;
  logic [LEN_W-1:0] cnt;
  logic             src_inc;
  logic             dst_inc;

  // Handshake: BUS_REQ is held from ARB through WR; BUS_GNT is only looked at
  // in ARB and at the end of WR, so a grant change during RD has no effect and
  // an RD is always followed by its WR.

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nxt = (LEN == '0) ? S_FIN : S_ARB;
        end
      end
      S_ARB: begin
        if (BUS_GNT) begin
          state_nxt = S_RD;
        end
      end
      S_RD:   state_nxt = S_WR;
      S_WR: begin
        if (cnt == LEN_W'(1)) begin
          state_nxt = S_FIN;
        end else if (BUS_GNT) begin
          state_nxt = S_RD;
        end else begin
          state_nxt = S_ARB;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides every other transition once a transfer is under way.
    if ((state != S_IDLE) && ABORT) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      data_reg <= '0;
      cnt      <= '0;
      src_inc  <= 1'b0;
      dst_inc  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            src_ptr <= SRC_ADDR;
            dst_ptr <= DST_ADDR;
            cnt     <= LEN;
            src_inc <= SRC_INC;
            dst_inc <= DST_INC;
          end
        end
        S_RD: begin
          data_reg <= IOBUS_IN;
        end
        S_WR: begin
          cnt <= cnt - LEN_W'(1);
          if (src_inc) begin
            src_ptr <= src_ptr + 32'd4;
          end
          if (dst_inc) begin
            dst_ptr <= dst_ptr + 32'd4;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bus outputs are zero outside RD/WR so the wrapper can OR them with the CPU.
  always_comb begin
    IOBUS_ADDR = 32'd0;
    IOBUS_OUT  = 32'd0;
    IOBUS_WR   = 1'b0;
    case (state)
      S_RD: begin
        IOBUS_ADDR = src_ptr;
      end
      S_WR: begin
        IOBUS_ADDR = dst_ptr;
        IOBUS_OUT  = data_reg;
        IOBUS_WR   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign BUSY      = (state != S_IDLE);
  assign DONE      = (state == S_FIN);
  assign BUS_REQ   = (state == S_ARB) || (state == S_RD) || (state == S_WR);
  assign dbg_state = state;

endmodule

// File: tb/tb_iobus_dma.sv
// Self-checking bench for iobus_dma: directed timing cases plus randomized
// transfers scored against a word-list model of the copy.
module tb_iobus_dma;
  localparam int LEN_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic             ABORT;
  logic [31:0]      SRC_ADDR;
  logic [31:0]      DST_ADDR;
  logic [LEN_W-1:0] LEN;
  logic             SRC_INC;
  logic             DST_INC;
  logic             BUSY;
  logic             DONE;
  logic             BUS_REQ;
  logic             BUS_GNT;
  logic [31:0]      IOBUS_ADDR;
  logic [31:0]      IOBUS_OUT;
  logic             IOBUS_WR;
  logic [31:0]      IOBUS_IN;
  logic [2:0]       dbg_state;

  iobus_dma #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .SRC_ADDR(SRC_ADDR), .DST_ADDR(DST_ADDR), .LEN(LEN),
    .SRC_INC(SRC_INC), .DST_INC(DST_INC),
    .BUSY(BUSY), .DONE(DONE), .BUS_REQ(BUS_REQ), .BUS_GNT(BUS_GNT),
    .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
    .IOBUS_IN(IOBUS_IN), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [63:0] exp_q[$];
  int wr_cyc_q[$];
  int done_cyc_q[$];
  logic [63:0] e;

  bit   use_rnd_gnt = 1'b0;
  logic gnt_drv = 1'b1;
  logic rnd_gnt = 1'b1;
  logic [15:0] switches = 16'hA5A5;

  assign BUS_GNT = use_rnd_gnt ? rnd_gnt : gnt_drv;

  always @(posedge CLK) cyc <= cyc + 1;

  // Peripheral model: the switch port at 0x11000000, elsewhere an injective
  // address-derived pattern so the write data identifies the address read.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h1100_0000) return {16'h0, switches};
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  assign IOBUS_IN = mem_rd(IOBUS_ADDR);

  initial forever begin
    @(posedge CLK);
    #1;
    rnd_gnt = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      if (!BUS_REQ) chk("idle_bus_zero", IOBUS_ADDR | IOBUS_OUT | {31'b0, IOBUS_WR}, 64'd0);
      if (IOBUS_WR) begin
        wr_cyc_q.push_back(cyc - t0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", IOBUS_ADDR, IOBUS_OUT);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr_data", {IOBUS_ADDR, IOBUS_OUT}, e);
        end
      end
      if (DONE) begin
        done_cnt++;
        done_cyc_q.push_back(cyc - t0);
        chk("done_after_writes", exp_q.size(), 0);
        chk("done_busy", BUSY, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l,
                            input bit si, input bit di, input int nexp, input bit exp_d);
    for (int i = 0; i < nexp; i++) begin
      exp_q.push_back({d + (di ? 32'(4 * i) : 32'd0), mem_rd(s + (si ? 32'(4 * i) : 32'd0))});
    end
    if (exp_d) exp_done++;
    @(posedge CLK);
    #1;
    wr_cyc_q.delete();
    done_cyc_q.delete();
    t0 = cyc;
    START = 1'b1;
    SRC_ADDR = s;
    DST_ADDR = d;
    LEN = l;
    SRC_INC = si;
    DST_INC = di;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    @(negedge CLK);
    while (cyc - t0 < n) @(negedge CLK);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (BUSY && k < 3000);
    chk("idle_timeout", BUSY, 0);
  endtask

  task automatic end_check(input string name);
    chk({name, "_done_count"}, done_cnt, exp_done);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic chk_cycles(input string name, input bit is_done, input int n,
                            input int c0, input int c1, input int c2);
    int q[$];
    int ev[3];
    if (is_done) q = done_cyc_q;
    else q = wr_cyc_q;
    ev[0] = c0;
    ev[1] = c1;
    ev[2] = c2;
    chk({name, "_count"}, q.size(), n);
    for (int i = 0; i < n && i < q.size() && i < 3; i++) chk(name, q[i], ev[i]);
  endtask

  task automatic chk_bus_quiet(input string name);
    chk({name, "_req"}, BUS_REQ, 1);
    chk({name, "_addr"}, IOBUS_ADDR, 0);
    chk({name, "_out"}, IOBUS_OUT, 0);
    chk({name, "_wr"}, IOBUS_WR, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    SRC_ADDR = '0;
    DST_ADDR = '0;
    LEN = '0;
    SRC_INC = 1'b0;
    DST_INC = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_req", BUS_REQ, 0);
    chk("rst_wr", IOBUS_WR, 0);
    chk("rst_addr", IOBUS_ADDR, 0);
    chk("rst_out", IOBUS_OUT, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Switch mirror, single word, fixed pointers.
    gnt_drv = 1'b1;
    start_xfer(32'h1100_0000, 32'h1100_0020, 8'd1, 1'b0, 1'b0, 1, 1'b1);
    wait_rel(2);
    chk("sw_rd_addr", IOBUS_ADDR, 32'h1100_0000);
    chk("sw_rd_wr", IOBUS_WR, 0);
    wait_rel(3);
    chk("sw_wr", IOBUS_WR, 1);
    chk("sw_wr_addr", IOBUS_ADDR, 32'h1100_0020);
    chk("sw_wr_out", IOBUS_OUT, 32'h0000_A5A5);
    wait_idle();
    chk_cycles("sw_done_cyc", 1'b1, 1, 4, 0, 0);
    chk_cycles("sw_wr_cyc", 1'b0, 1, 3, 0, 0);
    end_check("sw");

    // Incrementing pointers wrapping through zero.
    start_xfer(32'hFFFF_FFF8, 32'h0000_0200, 8'd3, 1'b1, 1'b1, 3, 1'b1);
    wait_idle();
    chk_cycles("wrap_wr_cyc", 1'b0, 3, 3, 5, 7);
    chk_cycles("wrap_done_cyc", 1'b1, 1, 8, 0, 0);
    end_check("wrap");

    // Grant withheld for cycles 1..5.
    gnt_drv = 1'b0;
    start_xfer(32'h0000_0100, 32'h0000_0140, 8'd1, 1'b1, 1'b0, 1, 1'b1);
    for (int r = 1; r <= 5; r++) begin
      wait_rel(r);
      chk_bus_quiet("nognt");
    end
    @(posedge CLK);
    #1;
    gnt_drv = 1'b1;
    wait_idle();
    chk_cycles("nognt_wr_cyc", 1'b0, 1, 8, 0, 0);
    chk_cycles("nognt_done_cyc", 1'b1, 1, 9, 0, 0);
    end_check("nognt");

    // Grant dropped during the first WR and restored three cycles later.
    start_xfer(32'h0000_0300, 32'h0000_0400, 8'd2, 1'b1, 1'b1, 2, 1'b1);
    wait_rel(2);
    @(posedge CLK);
    #1;
    gnt_drv = 1'b0;
    wait_rel(4);
    chk_bus_quiet("drop4");
    wait_rel(5);
    chk_bus_quiet("drop5");
    @(posedge CLK);
    #1;
    gnt_drv = 1'b1;
    wait_idle();
    chk_cycles("drop_wr_cyc", 1'b0, 2, 3, 8, 0);
    chk_cycles("drop_done_cyc", 1'b1, 1, 9, 0, 0);
    end_check("drop");

    // Zero length: immediate DONE, no bus activity.
    start_xfer(32'h1100_0000, 32'h0000_0500, 8'd0, 1'b1, 1'b1, 0, 1'b1);
    wait_idle();
    chk_cycles("len0_done_cyc", 1'b1, 1, 1, 0, 0);
    chk_cycles("len0_wr_cyc", 1'b0, 0, 0, 0, 0);
    end_check("len0");

    // START pulses while busy must not disturb the running transfer.
    start_xfer(32'h0000_0600, 32'h0000_0700, 8'd4, 1'b1, 1'b1, 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK);
      #1;
      START = 1'b1;
      SRC_ADDR = $urandom;
      DST_ADDR = $urandom;
      LEN = LEN_W'($urandom_range(1, 9));
      SRC_INC = 1'($urandom_range(0, 1));
      DST_INC = 1'($urandom_range(0, 1));
      @(posedge CLK);
      #1;
      START = 1'b0;
    end
    wait_idle();
    chk_cycles("busy_start_done_cyc", 1'b1, 1, 10, 0, 0);
    end_check("busy_start");

    // Abort during RD of word 2.
    start_xfer(32'h0000_0800, 32'h0000_0900, 8'd4, 1'b1, 1'b1, 1, 1'b0);
    wait_rel(3);
    @(posedge CLK);
    #1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    chk("abort_busy", BUSY, 0);
    chk("abort_req", BUS_REQ, 0);
    repeat (5) @(negedge CLK);
    wait_idle();
    chk_cycles("abort_wr_cyc", 1'b0, 1, 3, 0, 0);
    chk_cycles("abort_done_cyc", 1'b1, 0, 0, 0, 0);
    end_check("abort");
    start_xfer(32'h0000_0A00, 32'h1100_0040, 8'd2, 1'b1, 1'b0, 2, 1'b1);
    wait_idle();
    end_check("post_abort");

    // Reset asserted in the middle of a WR cycle.
    start_xfer(32'h0000_0C00, 32'h0000_0D00, 8'd3, 1'b1, 1'b1, 0, 1'b0);
    wait_rel(2);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_mid_wr", IOBUS_WR, 0);
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_req", BUS_REQ, 0);
    chk("rst_mid_addr", IOBUS_ADDR, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    end_check("rst_mid");
    start_xfer(32'h0000_0E00, 32'h0000_0F00, 8'd3, 1'b1, 1'b1, 3, 1'b1);
    wait_idle();
    chk_cycles("post_rst_wr_cyc", 1'b0, 3, 3, 5, 7);
    end_check("post_rst");

    // Randomized transfers under a randomly toggling grant.
    use_rnd_gnt = 1'b1;
    for (int it = 0; it < 30; it++) begin
      logic [31:0] s;
      logic [31:0] d;
      int l;
      s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      d = $urandom;
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      start_xfer(s, d, LEN_W'(l), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l, 1'b1);
      wait_idle();
      end_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
